// File: rtl/rx_pkg.sv
`default_nettype none
//============================================================================
// Module : rx_pkg
// Brief  : Shared types and constants for the ZigBee receive frame parser.
// Rev    : 1.0  initial release
//============================================================================
package rx_pkg;

  // Parser states: preamble/SFD hunt, length byte, payload streaming.
  typedef enum logic [1:0] {
    HUNT_PRE = 2'd0,
    PHR      = 2'd1,
    PAYLOAD  = 2'd2
  } rx_state_e;

  localparam logic [7:0] SFD_VALUE = 8'hA7;
  localparam int         MAX_PSDU  = 127;
  // Seven bits are enough to hold any legal PSDU length.
  localparam int         PHR_LEN_W = $clog2(MAX_PSDU + 1);

endpackage
`default_nettype wire

// File: rtl/fifo_pop_ctrl.sv
`default_nettype none
//============================================================================
// Module : fifo_pop_ctrl
// Brief  : Single-outstanding FIFO pop handshake plus in-frame stall timer.
//          A read issued in cycle N is sampled in cycle N+1; the stall timer
//          counts empty cycles with nothing in flight while enabled.
// Rev    : 1.0  initial release
//============================================================================
module fifo_pop_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic                  timer_en_i,
  output logic                  read_en_o,
  output logic                  sample_valid_o,
  output logic [DATA_WIDTH-1:0] sample_data_o,
  output logic                  timeout_o
);

  localparam int                   STALL_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic               pending_q;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  // A pop is only requested when nothing is in flight, which also keeps a
  // new read out of the cycle in which the previous one is sampled.
  assign read_en_o      = !fifo_empty_i && !pending_q;
  assign sample_valid_o = pending_q;
  assign sample_data_o  = fifo_data_i;
  assign timeout_o      = timer_en_i && (stall_q == STALL_LAST);

  // Stall counter next state: cleared outside frames and on every sample.
  always_comb begin
    stall_d = stall_q;
    if (!timer_en_i || pending_q) begin
      stall_d = '0;
    end else if (fifo_empty_i && (stall_q != STALL_LAST)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Pending flag and stall counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      pending_q <= read_en_o;
      stall_q   <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
//============================================================================
// Module : rx_frame_parser
// Brief  : Pops bytes from outFIFO, locks onto preamble + SFD, reads the PHR
//          length and streams the PSDU with start/end strobes and errors.
// Rev    : 1.0  initial release
//============================================================================
module rx_frame_parser #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    PREAMBLE_BYTES = 4,
  parameter logic [DATA_WIDTH-1:0] SFD_VALUE      = DATA_WIDTH'(rx_pkg::SFD_VALUE),
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  inClock,
  input  logic                  inReset,
  input  logic [DATA_WIDTH-1:0] inFifoData,
  input  logic                  inFifoEmpty,
  output logic                  outFifoReadEnable,
  output logic [DATA_WIDTH-1:0] outByte,
  output logic                  outByteValid,
  output logic                  outFrameStart,
  output logic                  outFrameEnd,
  output logic [6:0]            outLength,
  output logic                  outLengthError,
  output logic                  outTimeoutError,
  output logic                  outBusy
);

  import rx_pkg::*;

  localparam int                 PRE_W   = $clog2(PREAMBLE_BYTES + 1);
  localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(PREAMBLE_BYTES);

  rx_state_e              state_q, state_d;
  logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic [PHR_LEN_W-1:0]   remaining_q, remaining_d;
  logic [PHR_LEN_W-1:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0]  byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   start_q, start_d;
  logic                   end_q, end_d;
  logic                   len_err_q, len_err_d;
  logic                   tmo_q, tmo_d;

  logic                   sample_valid;
  logic [DATA_WIDTH-1:0]  sample_data;
  logic                   timeout;
  logic                   timer_en;

  assign timer_en = (state_q != HUNT_PRE);

  fifo_pop_ctrl #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_pop (
    .clk_i          (inClock),
    .rst_i          (inReset),
    .fifo_data_i    (inFifoData),
    .fifo_empty_i   (inFifoEmpty),
    .timer_en_i     (timer_en),
    .read_en_o      (outFifoReadEnable),
    .sample_valid_o (sample_valid),
    .sample_data_o  (sample_data),
    .timeout_o      (timeout)
  );

  // Next-state and registered-output decode for the parser FSM.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;
    len_err_d    = 1'b0;
    tmo_d        = 1'b0;
    case (state_q)
      HUNT_PRE: begin
        if (sample_valid) begin
          if (sample_data == '0) begin
            // Long preambles are fine: the count just saturates.
            if (pre_cnt_q != PRE_MAX) begin
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
          end else if ((sample_data == SFD_VALUE) && (pre_cnt_q == PRE_MAX)) begin
            pre_cnt_d = '0;
            state_d   = PHR;
          end else begin
            pre_cnt_d = '0;
          end
        end
      end
      PHR: begin
        if (timeout) begin
          tmo_d   = 1'b1;
          state_d = HUNT_PRE;
        end else if (sample_valid) begin
          // Bit 7 of the PHR is reserved and dropped here.
          len_d = sample_data[PHR_LEN_W-1:0];
          if (sample_data[PHR_LEN_W-1:0] == '0) begin
            len_err_d = 1'b1;
            state_d   = HUNT_PRE;
          end else begin
            remaining_d = sample_data[PHR_LEN_W-1:0];
            state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (timeout) begin
          tmo_d   = 1'b1;
          state_d = HUNT_PRE;
        end else if (sample_valid) begin
          byte_d       = sample_data;
          byte_valid_d = 1'b1;
          start_d      = (remaining_q == len_q);
          remaining_d  = remaining_q - 1'b1;
          if (remaining_q == PHR_LEN_W'(1)) begin
            end_d     = 1'b1;
            pre_cnt_d = '0;
            state_d   = HUNT_PRE;
          end
        end
      end
      default: begin
        state_d   = HUNT_PRE;
        pre_cnt_d = '0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_q      <= HUNT_PRE;
      pre_cnt_q    <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      len_err_q    <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      start_q      <= start_d;
      end_q        <= end_d;
      len_err_q    <= len_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign outByte         = byte_q;
  assign outByteValid    = byte_valid_q;
  assign outFrameStart   = start_q;
  assign outFrameEnd     = end_q;
  assign outLength       = len_q;
  assign outLengthError  = len_err_q;
  assign outTimeoutError = tmo_q;
  assign outBusy         = (state_q == PHR) || (state_q == PAYLOAD);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
//============================================================================
// Module : tb_rx_frame_parser
// Brief  : Directed bench for rx_frame_parser with a queue-backed FIFO model
//          and an output monitor collecting payload bytes and error pulses.
// Rev    : 1.0  initial release
//============================================================================
module tb_rx_frame_parser;

  logic       inClock = 1'b0;
  logic       inReset = 1'b1;
  logic [7:0] inFifoData = 8'h00;
  logic       inFifoEmpty = 1'b1;
  logic       outFifoReadEnable;
  logic [7:0] outByte;
  logic       outByteValid;
  logic       outFrameStart;
  logic       outFrameEnd;
  logic [6:0] outLength;
  logic       outLengthError;
  logic       outTimeoutError;
  logic       outBusy;

  rx_frame_parser dut (
    .inClock           (inClock),
    .inReset           (inReset),
    .inFifoData        (inFifoData),
    .inFifoEmpty       (inFifoEmpty),
    .outFifoReadEnable (outFifoReadEnable),
    .outByte           (outByte),
    .outByteValid      (outByteValid),
    .outFrameStart     (outFrameStart),
    .outFrameEnd       (outFrameEnd),
    .outLength         (outLength),
    .outLengthError    (outLengthError),
    .outTimeoutError   (outTimeoutError),
    .outBusy           (outBusy)
  );

  initial forever #5 inClock = ~inClock;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] mon_b[$];
  logic       mon_s[$];
  logic       mon_e[$];
  int         lerr_n = 0;
  int         tmo_n  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // FIFO model: a pop requested in one cycle presents data in the next.
  initial begin
    logic rd;
    forever begin
      @(negedge inClock);
      rd = outFifoReadEnable;
      @(posedge inClock);
      #1;
      if (rd && fifo_q.size() > 0) inFifoData = fifo_q.pop_front();
      inFifoEmpty = (fifo_q.size() == 0);
    end
  end

  // Output monitor.
  initial forever begin
    @(negedge inClock);
    if (outByteValid) begin
      mon_b.push_back(outByte);
      mon_s.push_back(outFrameStart);
      mon_e.push_back(outFrameEnd);
    end
    if (outLengthError)  lerr_n++;
    if (outTimeoutError) tmo_n++;
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic push_shr(input int npre);
    for (int i = 0; i < npre; i++) push(8'h00);
    push(8'hA7);
  endtask

  task automatic clr();
    mon_b.delete();
    mon_s.delete();
    mon_e.delete();
    lerr_n = 0;
    tmo_n  = 0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || !inFifoEmpty) && k < 2000) begin
      @(posedge inClock);
      k++;
    end
    check({tag, "_drain"}, 32'(k < 2000), 32'd1);
    repeat (8) @(posedge inClock);
    @(negedge inClock);
    #1;
  endtask

  // bytes holds up to four expected payload bytes, first byte most significant.
  task automatic check_frame(input string tag, input logic [31:0] bytes, input int n,
                             input bit complete);
    check({tag, "_count"}, mon_b.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < mon_b.size()) begin
        check($sformatf("%s_byte%0d", tag, i), mon_b[i], bytes[8*(n-1-i) +: 8]);
        check($sformatf("%s_start%0d", tag, i), mon_s[i], 32'(i == 0));
        check($sformatf("%s_end%0d", tag, i), mon_e[i], 32'(complete && (i == n-1)));
      end
    end
  endtask

  initial begin
    int k;
    // Reset
    repeat (3) @(posedge inClock);
    #1 inReset = 1'b0;
    @(negedge inClock);
    check("rst_valid", outByteValid, 0);
    check("rst_start", outFrameStart, 0);
    check("rst_end", outFrameEnd, 0);
    check("rst_len", outLength, 0);
    check("rst_lerr", outLengthError, 0);
    check("rst_tmo", outTimeoutError, 0);
    check("rst_busy", outBusy, 0);
    check("rst_byte", outByte, 0);

    // Nominal three-byte frame
    clr();
    push_shr(4); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
    drain("t1");
    check_frame("t1", 32'h00112233, 3, 1);
    check("t1_len", outLength, 3);
    check("t1_busy", outBusy, 0);
    check("t1_lerr", lerr_n, 0);
    check("t1_tmo", tmo_n, 0);

    // Short preamble is rejected
    clr();
    push_shr(3); push(8'h03); push(8'h11); push(8'h22); push(8'h33);
    drain("t2");
    check("t2_count", mon_b.size(), 0);
    check("t2_busy", outBusy, 0);
    check("t2_len_held", outLength, 3);

    // Long preamble, PHR 0x80 -> length 0 error
    clr();
    push_shr(6); push(8'h80);
    drain("t3");
    check("t3_lerr", lerr_n, 1);
    check("t3_count", mon_b.size(), 0);
    check("t3_len", outLength, 0);
    check("t3_busy", outBusy, 0);

    // Stall timeout mid-payload, then a good frame
    clr();
    push_shr(4); push(8'h05); push(8'hAA); push(8'hBB);
    drain("t4");
    check("t4_busy_stall", outBusy, 1);
    repeat (1100) @(posedge inClock);
    @(negedge inClock);
    check("t4_tmo", tmo_n, 1);
    check_frame("t4", 32'h0000AABB, 2, 0);
    check("t4_busy", outBusy, 0);
    clr();
    push_shr(4); push(8'h02); push(8'hC1); push(8'hC2);
    drain("t4b");
    check_frame("t4b", 32'h0000C1C2, 2, 1);
    check("t4b_len", outLength, 2);
    check("t4b_tmo", tmo_n, 0);

    // Single-byte frame
    clr();
    push_shr(4); push(8'h01); push(8'h5C);
    drain("t5");
    check_frame("t5", 32'h0000005C, 1, 1);
    check("t5_len", outLength, 1);

    // Reset after the second byte of a ten-byte payload
    clr();
    push_shr(4); push(8'h0A);
    for (int i = 1; i <= 10; i++) push(8'(i));
    k = 0;
    while (mon_b.size() < 2 && k < 200) begin
      @(negedge inClock);
      #1;
      k++;
    end
    check("t6_wait", 32'(k < 200), 32'd1);
    inReset = 1'b1;
    @(posedge inClock);
    #1 inReset = 1'b0;
    check("t6_valid", outByteValid, 0);
    check("t6_start", outFrameStart, 0);
    check("t6_end", outFrameEnd, 0);
    check("t6_len", outLength, 0);
    check("t6_busy", outBusy, 0);
    check("t6_byte", outByte, 0);
    drain("t6");
    check_frame("t6", 32'h00000102, 2, 0);
    clr();
    push_shr(4); push(8'h01); push(8'h77);
    drain("t6b");
    check_frame("t6b", 32'h00000077, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_frame_parser.md
Name: rx_frame_parser

Overview:
- Downstream consumer of outFIFO in the ZigBee receive path.
- Pops assembled bytes from the FIFO and hunts for the 802.15.4 synchronisation header: the preamble (PREAMBLE_BYTES × 0x00) followed by the SFD (0xA7).
- Then reads the PHR length byte and streams exactly that many PSDU bytes to the MAC side, with start/end strobes and error flags.

Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- PREAMBLE_BYTES, 4, consecutive 0x00 bytes required before the SFD.
- SFD_VALUE, 8'hA7, start-of-frame delimiter.
- TIMEOUT_CYCLES, 1024, maximum inFifoEmpty stall inside a frame before abort.

Ports:
- inClock  in  1  system clock.
- inReset  in  1  reset.
- inFifoData  in  DATA_WIDTH  FIFO read data; valid the cycle after outFifoReadEnable.
- inFifoEmpty  in  1  FIFO empty flag.
- outFifoReadEnable  out  1  single-cycle pop request.
- outByte  out  DATA_WIDTH  payload byte.
- outByteValid  out  1  outByte qualifier, one-cycle pulse per byte.
- outFrameStart  out  1  high with the first payload byte.
- outFrameEnd  out  1  high with the last payload byte.
- outLength  out  7  PHR frame length; held from PHR capture until the next PHR.
- outLengthError  out  1  one-cycle pulse when PHR length == 0.
- outTimeoutError  out  1  one-cycle pulse on in-frame stall timeout.
- outBusy  out  1  high in PHR and PAYLOAD states.

Behaviour:
- Clock and reset:
  - One clock, inClock.
  - inReset is synchronous and active-high.
  - On reset, all outputs go to 0, the state goes to HUNT_PRE, and all counters clear.
- Read handshake:
  - outFifoReadEnable is asserted for one cycle when !inFifoEmpty and no read is pending.
  - A pending flag is set by the read; inFifoData is sampled on the next cycle and the flag clears.
  - At most one outstanding read. Maximum throughput is one byte per 2 cycles.
  - No read is issued in the same cycle as a sample.
- States:
  - HUNT_PRE
    - Byte 0x00: increment preCnt, saturating at PREAMBLE_BYTES.
    - Byte == SFD_VALUE with preCnt == PREAMBLE_BYTES: go to PHR.
    - Any other byte: preCnt = 0 and stay.
    - Extra 0x00 bytes beyond PREAMBLE_BYTES are accepted.
  - PHR
    - len = byte[6:0]; bit 7 is reserved and ignored. outLength = len.
    - len == 0: pulse outLengthError, go to HUNT_PRE.
    - Otherwise: remaining = len, go to PAYLOAD.
  - PAYLOAD
    - Each sampled byte drives outByte/outByteValid in the cycle after sampling (registered, latency 1).
    - outFrameStart is high on the first byte, i.e. when remaining == len.
    - outFrameEnd is high when remaining == 1; then go to HUNT_PRE with preCnt = 0.
    - For len == 1, outFrameStart and outFrameEnd are high together.
- Timeout:
  - In PHR and PAYLOAD, a stall counter counts cycles with inFifoEmpty high and no pending read, and resets on every sample.
  - Reaching TIMEOUT_CYCLES-1: pulse outTimeoutError, go to HUNT_PRE, drop the partial frame.
  - No outFrameEnd is produced for a dropped frame.
- Reset mid-frame: immediate return to HUNT_PRE; no end strobe; a pending read is discarded.
- FIFO empty in HUNT_PRE: wait indefinitely; no timeout.
- Widths:
  - remaining is 7 bits; the stall counter is $clog2(TIMEOUT_CYCLES) bits.
  - preCnt is $clog2(PREAMBLE_BYTES+1) bits.

Decomposition:
- Package rx_pkg:
  - state enum {HUNT_PRE, PHR, PAYLOAD}.
  - SFD_VALUE and PHR_LEN_W = 7.
  - MAX_PSDU = 127.
- Sub-module fifo_pop_ctrl: pending-flag read handshake and stall/timeout counter. It outputs sampleValid, sampleData and timeout to the FSM.

Test Plan:
- Stream 00 00 00 00 A7 03 11 22 33 -> outLength=3; bytes 11, 22, 33 with outByteValid; outFrameStart on 11, outFrameEnd on 33; outBusy low afterwards.
- Stream 00 00 00 A7 03 11 22 33 (short preamble) -> no outByteValid; parser stays in HUNT_PRE.
- Stream 00 00 00 00 00 00 A7 80 -> bit 7 ignored, len=0; outLengthError pulses once; no payload output.
- Stream 00×4 A7 05 AA BB, then hold FIFO empty for 1024 cycles -> outTimeoutError pulses once; two bytes are output, no outFrameEnd; a following valid frame parses correctly.
- Stream 00×4 A7 01 5C -> single byte 5C with outFrameStart and outFrameEnd both high in the same cycle.
- Assert inReset for 1 cycle after byte 2 of a 10-byte payload -> all outputs 0 next cycle; following bytes are ignored until a new preamble + SFD.
